// File: rtl/skein_nonce_scanner.sv
// skein_nonce_scanner
//   Feeds a nonce range into the Skein-512 pipeline, follows each issued nonce
//   through the pipeline with a latency-matched tag line, compares the top
//   64 bits of every returned hash against a target, and queues winning
//   nonces in a small FIFO.
//
// Ports
//   clk, reset        clock, synchronous active-high reset
//   start, abort      begin a scan (IDLE only) / stop issuing (RUN only)
//   nonce_first/last  inclusive nonce range, may wrap through 0xFFFFFFFF
//   target            win when hash_in[511:448] <= target (unsigned)
//   nonce_out         nonce presented to the core
//   hash_in           hash returned by the core
//   found_valid/ready/nonce  winning-nonce FIFO head, valid/ready handshake
//   busy, done        scan in progress / one-cycle end-of-drain pulse
//   overflow          sticky: a win was dropped on a full FIFO
//
// Build option: define SKEIN_SCAN_STATS_EN to add output hashes_checked[31:0],
// a saturating count of hashes examined since the last accepted start.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | issuing one nonce every ISSUE_INTERVAL cycles
// DRAIN | issuing stopped, waiting for in-flight tags to return
module skein_nonce_scanner #(
  parameter int PIPE_LATENCY   = 145,
  parameter int ISSUE_INTERVAL = 2,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         abort,
  input  logic [31:0]  nonce_first,
  input  logic [31:0]  nonce_last,
  input  logic [63:0]  target,
  output logic [31:0]  nonce_out,
  input  logic [511:0] hash_in,
  output logic         found_valid,
  input  logic         found_ready,
  output logic [31:0]  found_nonce,
  output logic         busy,
  output logic         done,
  output logic         overflow
`ifdef SKEIN_SCAN_STATS_EN
  ,
  output logic [31:0]  hashes_checked
`endif
);

  localparam int PW = (ISSUE_INTERVAL > 1) ? $clog2(ISSUE_INTERVAL) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t state_q, state_d;

  logic [PW-1:0]           phase_q;
  logic [31:0]             issue_ctr;
  logic [31:0]             res_ctr;
  logic [31:0]             last_l;
  logic [63:0]             target_l;
  logic [PIPE_LATENCY-1:0] tag_q;
  logic                    tag_o;
  logic                    issue;
  logic                    load;
  logic                    done_d;

  // Only the top word of the hash takes part in the comparison.
  logic unused_hash_low;
  assign unused_hash_low = ^hash_in[447:0];

  assign tag_o = tag_q[PIPE_LATENCY-1];
  assign busy  = (state_q != S_IDLE);

  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    load    = 1'b0;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        issue = (phase_q == '0);
        // An abort landing on an issue cycle still lets that nonce go out.
        if ((issue && (issue_ctr == last_l)) || abort) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (tag_q == '0) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      phase_q   <= '0;
      issue_ctr <= '0;
      res_ctr   <= '0;
      last_l    <= '0;
      target_l  <= '0;
      nonce_out <= '0;
      tag_q     <= '0;
      done      <= 1'b0;
    end else begin
      state_q <= state_d;
      done    <= done_d;
      tag_q   <= {tag_q[PIPE_LATENCY-2:0], issue};
      if (load) begin
        issue_ctr <= nonce_first;
        res_ctr   <= nonce_first;
        last_l    <= nonce_last;
        target_l  <= target;
        phase_q   <= '0;
      end else begin
        if (state_q == S_RUN)
          phase_q <= (phase_q == PW'(ISSUE_INTERVAL - 1)) ? '0 : phase_q + PW'(1);
        if (issue) begin
          nonce_out <= issue_ctr;
          issue_ctr <= issue_ctr + 32'd1;
        end
        if (tag_o) res_ctr <= res_ctr + 32'd1;
      end
    end
  end

  // Found-nonce FIFO. The output head is a register refreshed from the
  // memory state before this cycle's write, so a fresh entry shows up one
  // cycle after it is written.
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_next;
  logic [CW-1:0] count;
  logic          win, pop, full, push, drop, head_valid_d;

  assign win     = tag_o && (hash_in[511:448] <= target_l);
  assign pop     = found_valid && found_ready;
  assign full    = (count == CW'(FIFO_DEPTH));
  assign push    = win && (!full || pop);
  assign drop    = win && full && !pop;
  assign rd_next = rd_ptr + AW'(1);
  assign head_valid_d = pop ? (count > CW'(1)) : (count != '0);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= res_ctr;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      found_valid <= 1'b0;
      found_nonce <= '0;
      overflow    <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_next;
      if (push && !pop)      count <= count + CW'(1);
      else if (!push && pop) count <= count - CW'(1);
      found_valid <= head_valid_d;
      if (head_valid_d) found_nonce <= pop ? mem[rd_next] : mem[rd_ptr];
      if (load)      overflow <= 1'b0;
      else if (drop) overflow <= 1'b1;
    end
  end

`ifdef SKEIN_SCAN_STATS_EN
  always_ff @(posedge clk) begin
    if (reset || load)                   hashes_checked <= '0;
    else if (tag_o && (hashes_checked != '1)) hashes_checked <= hashes_checked + 32'd1;
  end
`endif

endmodule

// File: tb/tb_skein_nonce_scanner.sv
module tb_skein_nonce_scanner;

  logic         clk = 1'b0;
  logic         reset, start, abort;
  logic [31:0]  nonce_first, nonce_last;
  logic [63:0]  target;
  logic [31:0]  nonce_out;
  logic [511:0] hash_in;
  logic         found_valid, found_ready;
  logic [31:0]  found_nonce;
  logic         busy, done, overflow;
`ifdef SKEIN_SCAN_STATS_EN
  logic [31:0]  hashes_checked;
`endif

  skein_nonce_scanner dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .nonce_first(nonce_first), .nonce_last(nonce_last), .target(target),
    .nonce_out(nonce_out), .hash_in(hash_in),
    .found_valid(found_valid), .found_ready(found_ready), .found_nonce(found_nonce),
    .busy(busy), .done(done), .overflow(overflow)
`ifdef SKEIN_SCAN_STATS_EN
    , .hashes_checked(hashes_checked)
`endif
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  logic mode = 1'b0;
  logic [31:0] hist [145];
  logic [31:0] got [$];

  always @(posedge clk) cyc <= cyc + 1;

  // Core model: hash top word is a function of the nonce seen 144 cycles ago.
  function automatic logic [63:0] hash_top(input logic [31:0] n);
    if (mode == 1'b0) return 64'd0;
    return (n == 32'd5) ? 64'h0000_0001_0000_0000 : 64'h0000_0001_0000_0001;
  endfunction

  always @(negedge clk) begin
    if (found_valid && found_ready) got.push_back(found_nonce);
    if (done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
    end
    for (int i = 144; i > 0; i--) hist[i] <= hist[i-1];
    hist[0] <= nonce_out;
    hash_in <= {hash_top(hist[143]), 448'd0};
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic wait_done(input int d0);
    int n = 0;
    while (done_cnt == d0 && n < 500) begin
      tick();
      n++;
    end
    check("done_seen", 64'(done_cnt != d0), 64'd1);
  endtask

  typedef struct packed {
    logic [31:0]       first;
    logic [31:0]       last;
    logic [63:0]       tgt;
    logic              mode;
    logic [2:0]        exp_cnt;
    logic [3:0][31:0]  exp_n;
  } vec_t;

  function automatic vec_t mk(input logic [31:0] f, input logic [31:0] l, input logic [63:0] t,
                              input logic m, input logic [2:0] c,
                              input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
    vec_t v;
    v.first = f; v.last = l; v.tgt = t; v.mode = m; v.exp_cnt = c;
    v.exp_n[0] = e0; v.exp_n[1] = e1; v.exp_n[2] = e2; v.exp_n[3] = e3;
    return v;
  endfunction

  vec_t vecs [6];

  initial begin
    int s, n, d0, d1;
    logic seq_ok;

    vecs[0] = mk(32'h10, 32'h13, '1, 1'b0, 3'd4, 32'h10, 32'h11, 32'h12, 32'h13);
    vecs[1] = mk(32'h0, 32'h9, 64'h0000_0001_0000_0000, 1'b1, 3'd1, 32'h5, 0, 0, 0);
    vecs[2] = mk(32'hFFFF_FFFE, 32'h1, '1, 1'b0, 3'd4, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0, 32'h1);
    vecs[3] = mk(32'h7, 32'h7, '1, 1'b0, 3'd1, 32'h7, 0, 0, 0);
    vecs[4] = mk(32'h0, 32'h9, 64'h0000_0000_FFFF_FFFF, 1'b1, 3'd0, 0, 0, 0, 0);
    vecs[5] = mk(32'h100, 32'h101, 64'd0, 1'b0, 3'd2, 32'h100, 32'h101, 0, 0);

    for (int i = 0; i < 145; i++) hist[i] = '0;
    reset = 1'b1; start = 1'b0; abort = 1'b0; found_ready = 1'b0;
    nonce_first = '0; nonce_last = '0; target = '0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    check("rst_nonce_out", 64'(nonce_out), 64'd0);
    check("rst_found_valid", 64'(found_valid), 64'd0);
    check("rst_found_nonce", 64'(found_nonce), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_overflow", 64'(overflow), 64'd0);

    found_ready = 1'b1;
    for (int vi = 0; vi < 6; vi++) begin
      mode = vecs[vi].mode;
      nonce_first = vecs[vi].first;
      nonce_last  = vecs[vi].last;
      target      = vecs[vi].tgt;
      n = int'(vecs[vi].last - vecs[vi].first) + 1;
      got.delete();
      d0 = done_cnt;
      start = 1'b1;
      tick();
      start = 1'b0;
      s = cyc;
      seq_ok = 1'b1;
      for (int k = 1; k <= 2 * n; k++) begin
        tick();
        if (k == 1) check("run_busy", 64'(busy), 64'd1);
        if (nonce_out !== vecs[vi].first + 32'((k - 1) / 2)) seq_ok = 1'b0;
      end
      check("nonce_seq", 64'(seq_ok), 64'd1);
      wait_done(d0);
      check("done_latency", 64'(done_cyc - s), 64'(2 * n + 145));
      repeat (4) tick();
      check("idle_busy", 64'(busy), 64'd0);
      check("win_count", 64'(got.size()), 64'(vecs[vi].exp_cnt));
      for (int j = 0; j < int'(vecs[vi].exp_cnt); j++)
        if (j < got.size()) check("win_nonce", 64'(got[j]), 64'(vecs[vi].exp_n[j]));
      check("no_overflow", 64'(overflow), 64'd0);
    end

    // Six wins with the consumer stalled: four kept, overflow set.
    mode = 1'b0; target = '1; nonce_first = 32'h20; nonce_last = 32'h25;
    found_ready = 1'b0;
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    wait_done(d0);
    repeat (2) tick();
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_valid", 64'(found_valid), 64'd1);
    check("ovf_head", 64'(found_nonce), 64'h20);
    got.delete();
    found_ready = 1'b1;
    repeat (4) tick();
    found_ready = 1'b0;
    check("ovf_drain_cnt", 64'(got.size()), 64'd4);
    for (int j = 0; j < 4; j++)
      if (j < got.size()) check("ovf_drain_nonce", 64'(got[j]), 64'(32'h20 + j));
    check("ovf_empty", 64'(found_valid), 64'd0);

    // Abort ten cycles into a long scan; start in DRAIN is ignored.
    nonce_first = 32'h0; nonce_last = 32'd999;
    found_ready = 1'b1;
    got.delete();
    d0 = done_cnt;
    start = 1'b1; tick(); start = 1'b0;
    s = cyc;
    check("abort_ovf_cleared", 64'(overflow), 64'd0);
    repeat (9) tick();
    check("abort_last_issue", 64'(nonce_out), 64'd4);
    abort = 1'b1; tick(); abort = 1'b0;
    check("abort_drain_busy", 64'(busy), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    wait_done(d0);
    check("abort_done_latency", 64'(done_cyc - s), 64'd155);
    repeat (4) tick();
    check("abort_win_cnt", 64'(got.size()), 64'd5);
    for (int j = 0; j < 5; j++)
      if (j < got.size()) check("abort_win_nonce", 64'(got[j]), 64'(j));
    d1 = done_cnt;
    repeat (200) tick();
    check("abort_done_once", 64'(done_cnt), 64'(d1));
    check("abort_idle", 64'(busy), 64'd0);
    check("abort_no_late", 64'(got.size()), 64'd5);

    // Reset with three wins queued and more tags in flight.
    nonce_first = 32'h40; nonce_last = 32'h4F;
    found_ready = 1'b0;
    start = 1'b1; tick(); start = 1'b0;
    repeat (151) tick();
    check("pre_rst_valid", 64'(found_valid), 64'd1);
    reset = 1'b1; tick(); reset = 1'b0;
    check("mid_rst_valid", 64'(found_valid), 64'd0);
    check("mid_rst_busy", 64'(busy), 64'd0);
    check("mid_rst_overflow", 64'(overflow), 64'd0);
    check("mid_rst_nonce_out", 64'(nonce_out), 64'd0);
    got.delete();
    d0 = done_cnt;
    found_ready = 1'b1;
    repeat (200) tick();
    check("mid_rst_no_late", 64'(got.size()), 64'd0);
    check("mid_rst_no_done", 64'(done_cnt), 64'(d0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
